clk_div_ctrl: RTL and testbench

Run-time controller for the design's programmable clock divider. Sequences a divided output clock from one system clock: start/stop with glitch-free drain, threshold reconfiguration through a valid/ready port, and an optional burst mode that auto-stops after N output periods. Sits between the host/control logic and every consumer of a slow divided clock or enable tick.

---
 rtl/clk_div_ctrl_pkg.sv | 19 +
 rtl/clk_div_core.sv | 58 +++++
 rtl/clk_div_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// clk_div_ctrl_pkg: shared state encoding and default sizing for clk_div_ctrl.
// Revision: 1.0
// ============================================================================
package clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int          DEF_CNT_W       = 32;
  localparam int          DEF_BURST_W     = 16;
  localparam int unsigned DEF_THRESHOLD_C = 32'd25000000;

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
// clk_div_core: half-period counter and output toggle with rise/fall strobes.
// Revision: 1.0
// ============================================================================
module clk_div_core
  import clk_div_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] threshold_i,
  output logic             clk_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             clk_q, clk_d;
  logic             w_hit;

  // >= rather than == keeps the counter bounded if the threshold ever shrinks
  assign w_hit  = en_i && !clr_i && (count_q >= threshold_i);
  assign rise_o = w_hit && !clk_q;
  assign fall_o = w_hit && clk_q;
  assign clk_o  = clk_q;

  always_comb begin
    count_d = count_q;
    clk_d   = clk_q;
    if (clr_i) begin
      count_d = '0;
      clk_d   = 1'b0;
    end else if (en_i) begin
      if (w_hit) begin
        count_d = '0;
        clk_d   = !clk_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      clk_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      clk_q   <= clk_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// clk_div_ctrl: run-time sequencer for the programmable clock divider.
// Burst auto-stop is built only when CLK_DIV_CTRL_BURST_EN is defined. Rev 1.0
// ============================================================================
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int          CNT_W         = DEF_CNT_W,
  parameter int unsigned DEF_THRESHOLD = DEF_THRESHOLD_C,
  parameter int          BURST_W       = DEF_BURST_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CNT_W-1:0]   cfg_threshold_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               clk_o,
  output logic               tick_o,
  output logic               busy_o,
  output logic               done_o
);

`ifdef CLK_DIV_CTRL_BURST_EN
  localparam int              CFG_W   = CNT_W + BURST_W;
  localparam logic [CFG_W-1:0] CFG_RST = {BURST_W'(0), CNT_W'(DEF_THRESHOLD)};
`else
  localparam int              CFG_W   = CNT_W;
  localparam logic [CFG_W-1:0] CFG_RST = CNT_W'(DEF_THRESHOLD);
`endif

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             tick_q;

  // Active and shadow configuration words: {burst, threshold} or {threshold}
  logic [CFG_W-1:0] active_q, active_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic             sh_vld_q, sh_vld_d;
  logic [CFG_W-1:0] w_cfg_in;

  logic             w_clk;
  logic             w_rise;
  logic             w_fall;
  logic             w_cfg_acc;
  logic             w_trunc;
  logic             w_burst_end;
  logic             w_to_idle;
  logic             w_core_en;
  logic             w_core_clr;

`ifdef CLK_DIV_CTRL_BURST_EN
  logic [BURST_W-1:0] per_q, per_d;
  logic [BURST_W-1:0] w_burst;

  assign w_cfg_in    = {cfg_burst_i, cfg_threshold_i};
  assign w_burst     = active_q[CFG_W-1:CNT_W];
  // Burst compares against the configuration in force during the ending period
  assign w_burst_end = (state_q == ST_RUN) && w_fall && (w_burst != '0) &&
                       ((per_q + BURST_W'(1)) == w_burst);

  always_comb begin
    per_d = per_q;
    if (state_q == ST_IDLE) begin
      per_d = '0;
    end else if (w_fall) begin
      per_d = per_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end
`else
  logic w_unused_burst;

  assign w_cfg_in       = cfg_threshold_i;
  assign w_burst_end    = 1'b0;
  assign w_unused_burst = ^cfg_burst_i;
`endif

  assign w_cfg_acc  = cfg_valid_i && !sh_vld_q;
  // Low phase during drain is cut short; a started high phase always completes
  assign w_trunc    = (state_q == ST_DRAIN) && !w_clk;
  assign w_to_idle  = w_trunc || ((state_q == ST_DRAIN) && w_fall) || w_burst_end;
  assign w_core_en  = (state_q != ST_IDLE);
  assign w_core_clr = (state_q == ST_IDLE) || w_trunc;

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .en_i        (w_core_en),
    .clr_i       (w_core_clr),
    .threshold_i (active_q[CNT_W-1:0]),
    .clk_o       (w_clk),
    .rise_o      (w_rise),
    .fall_o      (w_fall)
  );

  always_comb begin
    active_d = active_q;
    shadow_d = shadow_q;
    sh_vld_d = sh_vld_q;
    if (state_q == ST_IDLE) begin
      if (w_cfg_acc) begin
        active_d = w_cfg_in;
      end
    end else begin
      if ((w_fall || w_to_idle) && sh_vld_q) begin
        active_d = shadow_q;
        sh_vld_d = 1'b0;
      end
      // A write landing on the final edge of a run has no later boundary
      if (w_cfg_acc) begin
        if (w_to_idle) begin
          active_d = w_cfg_in;
        end else begin
          shadow_d = w_cfg_in;
          sh_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_q <= CFG_RST;
      shadow_q <= '0;
      sh_vld_q <= 1'b0;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
      sh_vld_q <= sh_vld_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= w_rise | w_fall;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (w_to_idle) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if ((state_q == ST_RUN) && stop_i) begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready_o = !sh_vld_q;
  assign clk_o       = w_clk;
  assign tick_o      = tick_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// tb_clk_div_ctrl: directed and randomized checks of clk_div_ctrl against a
// cycle-level behavioural model. Rev 1.0
// ============================================================================
module tb_clk_div_ctrl;

  localparam int DEF_T = 6;
`ifdef CLK_DIV_CTRL_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [31:0] cfg_threshold_i = '0;
  logic [15:0] cfg_burst_i = '0;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        clk_o, tick_o, busy_o, done_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: mode, output level, edges left until next toggle, config, shadow
  int m_st, m_left, m_thr, m_burst, m_per, m_sthr, m_sburst;
  bit m_clk, m_shv, m_tick, m_done;

  clk_div_ctrl #(
    .CNT_W         (32),
    .DEF_THRESHOLD (DEF_T),
    .BURST_W       (16)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_threshold_i (cfg_threshold_i),
    .cfg_burst_i     (cfg_burst_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .clk_o           (clk_o),
    .tick_o          (tick_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_left = 0; m_thr = DEF_T; m_burst = 0; m_per = 0;
    m_sthr = 0; m_sburst = 0; m_clk = 0; m_shv = 0; m_tick = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    bit acc, fall, trunc, bend, idle;
    acc    = cfg_valid_i && !m_shv;
    m_tick = 0;
    m_done = 0;
    if (m_st == M_IDLE) begin
      if (acc) begin m_thr = int'(cfg_threshold_i); m_burst = int'(cfg_burst_i); end
      if (start_i && !stop_i) begin m_st = M_RUN; m_left = m_thr + 1; m_per = 0; end
    end else begin
      fall  = 0;
      trunc = (m_st == M_DRAIN) && !m_clk;
      if (!trunc) begin
        m_left--;
        if (m_left == 0) begin m_clk = !m_clk; m_tick = 1; fall = !m_clk; end
      end
      bend = 0;
      if (fall) begin
        m_per++;
        bend = BURST_ON && (m_burst != 0) && (m_per == m_burst);
      end
      idle = trunc || (m_st == M_DRAIN && fall) || (m_st == M_RUN && bend);
      if ((fall || idle) && m_shv) begin m_thr = m_sthr; m_burst = m_sburst; m_shv = 0; end
      if (idle) begin
        if (acc) begin m_thr = int'(cfg_threshold_i); m_burst = int'(cfg_burst_i); end
        m_st   = M_IDLE;
        m_done = 1;
      end else begin
        if (acc) begin m_sthr = int'(cfg_threshold_i); m_sburst = int'(cfg_burst_i); m_shv = 1; end
        if (m_st == M_RUN && stop_i) m_st = M_DRAIN;
        if (m_tick) m_left = m_thr + 1;
      end
    end
  endfunction

  task automatic compare_all();
    chk("clk_o", clk_o, m_clk);
    chk("tick_o", tick_o, m_tick);
    chk("busy_o", busy_o, m_st != M_IDLE);
    chk("done_o", done_o, m_done);
    chk("cfg_ready_o", cfg_ready_o, !m_shv);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    model_step();
    compare_all();
  endtask

  task automatic idle_cfg(input int thr, input int burst);
    cfg_valid_i = 1; cfg_threshold_i = thr; cfg_burst_i = 16'(burst);
    cycle();
    cfg_valid_i = 0;
  endtask

  task automatic do_start();
    start_i = 1; cycle(); start_i = 0;
  endtask

  task automatic go_idle();
    stop_i = 1;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (!busy_o) break;
    end
    stop_i = 0;
    chk("drain_timeout", busy_o, 0);
  endtask

  task automatic do_reset();
    #2 rst_n_i = 0;
    #1 model_reset();
    compare_all();
    #2 rst_n_i = 1;
  endtask

  initial begin
    int first, nt, nd, nb;
    logic [5:0] seq;
    model_reset();
    #3;
    compare_all();
    chk("rst_ready", cfg_ready_o, 1);
    chk("rst_clk", clk_o, 0);
    #10 rst_n_i = 1;

    // T=3: first rise 4 edges after start, tick every 4
    idle_cfg(3, 0);
    do_start();
    first = 0; nt = 0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      if (clk_o && first == 0) first = k;
      if (tick_o) nt++;
      if (k == 8) chk("t1_clk_k8", clk_o, 0);
    end
    chk("t1_first_rise", first, 4);
    chk("t1_ticks", nt, 4);
    stop_i = 1; cycle(); stop_i = 0;
    cycle();
    chk("t1_done", done_o, 1);
    chk("t1_busy", busy_o, 0);

    // T=0, burst=3
    idle_cfg(0, 3);
    do_start();
    seq = '0; nd = 0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k <= 6) seq = {seq[4:0], clk_o};
      if (k <= 5) chk("t2_tick", tick_o, 1);
      nd += int'(done_o);
    end
    chk("t2_seq", seq, 6'b101010);
    chk("t2_done_cnt", nd, BURST_ON ? 1 : 0);
    chk("t2_busy", busy_o, BURST_ON ? 0 : 1);
    go_idle();

    // T=5, write T=1 mid-high, second write refused while shadow full
    idle_cfg(5, 0);
    do_start();
    for (int k = 1; k <= 17; k++) begin
      cycle();
      case (k)
        6:  chk("t3_rise6", clk_o, 1);
        9:  chk("t3_ready9", cfg_ready_o, 0);
        11: chk("t3_ready11", cfg_ready_o, 0);
        12: begin chk("t3_ready12", cfg_ready_o, 1); chk("t3_clk12", clk_o, 0); end
        13: chk("t3_clk13", clk_o, 0);
        14: chk("t3_clk14", clk_o, 1);
        15: chk("t3_clk15", clk_o, 1);
        16: chk("t3_clk16", clk_o, 0);
        default: ;
      endcase
      cfg_valid_i     = (k >= 8 && k <= 10);
      cfg_threshold_i = (k == 8) ? 32'd1 : 32'd7;
    end
    cfg_valid_i = 0;
    go_idle();

    // T=4, stop during high phase then during low phase
    idle_cfg(4, 0);
    do_start();
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (k == 5) chk("t4_rise", clk_o, 1);
      if (k == 9) chk("t4_high9", clk_o, 1);
      stop_i = (k == 6);
    end
    chk("t4_clk_end", clk_o, 0);
    chk("t4_done", done_o, 1);
    chk("t4_busy", busy_o, 0);
    do_start();
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (k == 12) begin chk("t4b_busy12", busy_o, 1); chk("t4b_clk12", clk_o, 0); end
      stop_i = (k == 11);
    end
    chk("t4b_done", done_o, 1);
    chk("t4b_busy", busy_o, 0);

    // start and stop together in IDLE
    start_i = 1; stop_i = 1;
    nb = 0; nt = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      nb += int'(busy_o);
      nt += int'(tick_o);
    end
    start_i = 0; stop_i = 0;
    chk("t5_busy", nb, 0);
    chk("t5_ticks", nt, 0);

    // reset mid-run with shadow pending
    idle_cfg(3, 0);
    do_start();
    repeat (5) cycle();
    cfg_valid_i = 1; cfg_threshold_i = 9;
    cycle();
    cfg_valid_i = 0;
    chk("t6_shadow_full", cfg_ready_o, 0);
    do_reset();
    chk("t6_rst_ready", cfg_ready_o, 1);
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_clk", clk_o, 0);
    do_start();
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (clk_o && first == 0) first = k;
    end
    chk("t6_def_rise", first, DEF_T + 1);
    go_idle();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      start_i         = ($urandom_range(0, 7) == 0);
      stop_i          = ($urandom_range(0, 24) == 0);
      cfg_valid_i     = ($urandom_range(0, 5) == 0);
      cfg_threshold_i = $urandom_range(0, 5);
      cfg_burst_i     = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 799) == 0) do_reset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
